// File: rtl/bambu_mem_pkg.sv
// Shared definitions for the Bambu-style memory copy master: FSM states,
// default channel geometry and the access-size encoding helper.
package bambu_mem_pkg;

    localparam int DEF_ADDR_W     = 7;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_WAIT_LIMIT = 255;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_FIN  = 3'd3,
        ST_ERR  = 3'd4
    } copy_state_e;

    // Size field reports the access width in bits while a request is active.
    function automatic logic [3:0] access_size(input int width);
        return width[3:0];
    endfunction

endpackage

// File: rtl/bambu_mem_access_port.sv
// One-access memory port: drives oe/we/addr/wdata for the access the FSM
// requests, latches read data, and flags a timeout when the responder does
// not complete within WAIT_LIMIT cycles.
module bambu_mem_access_port
    import bambu_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WAIT_LIMIT = DEF_WAIT_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] M_Rdata_ram,
    input  logic              M_DataRdy,
    output logic              acc_done,
    output logic              acc_timeout,
    output logic              Mout_oe_ram,
    output logic              Mout_we_ram,
    output logic [ADDR_W-1:0] Mout_addr_ram,
    output logic [DATA_W-1:0] Mout_Wdata_ram,
    output logic [3:0]        Mout_data_ram_size
);

    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

    logic              active;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] rd_byte_p0;

    assign active = rd_req | wr_req;

    // Request drive is a pure decode of the FSM request so it stays stable
    // for the whole access and drops to zero the instant reset forces IDLE.
    always_comb begin
        Mout_oe_ram        = rd_req;
        Mout_we_ram        = wr_req & ~rd_req;
        Mout_addr_ram      = '0;
        Mout_Wdata_ram     = '0;
        Mout_data_ram_size = 4'd0;
        acc_done           = active & M_DataRdy;
        acc_timeout        = active & ~M_DataRdy &
                             (wait_cnt == WAIT_W'(WAIT_LIMIT - 1));
        if (rd_req) begin
            Mout_addr_ram      = rd_addr;
            Mout_data_ram_size = access_size(DATA_W);
        end else if (wr_req) begin
            Mout_addr_ram      = wr_addr;
            Mout_Wdata_ram     = rd_byte_p0;
            Mout_data_ram_size = access_size(DATA_W);
        end
    end

    // Wait counter restarts whenever an access ends or no access is active,
    // which is exactly every FSM state entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!active || acc_done || acc_timeout) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Read data is captured only on the completing read cycle.
    always_ff @(posedge clock) begin
        if (rd_req && M_DataRdy) begin
            rd_byte_p0 <= M_Rdata_ram;
        end
    end

endmodule

// File: rtl/bambu_copy_master.sv
// Byte-by-byte memory copy master: reads src+i, writes dst+i for i < len,
// then pulses done_port (with error_port on responder timeout).
module bambu_copy_master
    import bambu_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WAIT_LIMIT = DEF_WAIT_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_port,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [7:0]        len,
    output logic              done_port,
    output logic              error_port,
    output logic              busy,
    output logic              Mout_oe_ram,
    output logic              Mout_we_ram,
    output logic [ADDR_W-1:0] Mout_addr_ram,
    output logic [DATA_W-1:0] Mout_Wdata_ram,
    output logic [3:0]        Mout_data_ram_size,
    input  logic [DATA_W-1:0] M_Rdata_ram,
    input  logic              M_DataRdy
);

    copy_state_e       state_q;
    copy_state_e       state_d;
    logic              accept;
    logic              byte_inc;
    logic              rd_req;
    logic              wr_req;
    logic              acc_done;
    logic              acc_timeout;
    logic              last_byte;
    logic [7:0]        byte_cnt;
    logic [ADDR_W-1:0] src_p0;
    logic [ADDR_W-1:0] dst_p0;
    logic [7:0]        len_p0;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    // Addresses wrap modulo 2^ADDR_W by truncation of the sum.
    assign rd_addr   = src_p0 + ADDR_W'(byte_cnt);
    assign wr_addr   = dst_p0 + ADDR_W'(byte_cnt);
    assign last_byte = ((byte_cnt + 8'd1) == len_p0);

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; start and DataRdy matter only where used.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        byte_inc   = 1'b0;
        rd_req     = 1'b0;
        wr_req     = 1'b0;
        done_port  = 1'b0;
        error_port = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start_port) begin
                    accept  = 1'b1;
                    state_d = (len == 8'd0) ? ST_FIN : ST_RD;
                end
            end
            ST_RD: begin
                rd_req = 1'b1;
                if (acc_done) begin
                    state_d = ST_WR;
                end else if (acc_timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_WR: begin
                wr_req = 1'b1;
                if (acc_done) begin
                    byte_inc = 1'b1;
                    state_d  = last_byte ? ST_FIN : ST_RD;
                end else if (acc_timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_FIN: begin
                done_port = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_ERR: begin
                done_port  = 1'b1;
                error_port = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Transfer descriptor captured on an accepted start.
    always_ff @(posedge clock) begin
        if (accept) begin
            src_p0 <= src_addr;
            dst_p0 <= dst_addr;
            len_p0 <= len;
        end
    end

    // Byte counter: cleared on accept, advanced on each completed write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
        end else if (accept) begin
            byte_cnt <= '0;
        end else if (byte_inc) begin
            byte_cnt <= byte_cnt + 8'd1;
        end
    end

    bambu_mem_access_port #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_port (
        .clock              (clock),
        .reset              (reset),
        .rd_req             (rd_req),
        .wr_req             (wr_req),
        .rd_addr            (rd_addr),
        .wr_addr            (wr_addr),
        .M_Rdata_ram        (M_Rdata_ram),
        .M_DataRdy          (M_DataRdy),
        .acc_done           (acc_done),
        .acc_timeout        (acc_timeout),
        .Mout_oe_ram        (Mout_oe_ram),
        .Mout_we_ram        (Mout_we_ram),
        .Mout_addr_ram      (Mout_addr_ram),
        .Mout_Wdata_ram     (Mout_Wdata_ram),
        .Mout_data_ram_size (Mout_data_ram_size)
    );

endmodule

// File: tb/tb_bambu_copy_master.sv
// Bench for bambu_copy_master: a delay-programmable memory responder, a
// cycle-level expectation script built from the copy rules, and a compare
// process that checks every output on every falling edge.
module tb_bambu_copy_master;

    localparam int WL = 8;

    logic       clock;
    logic       reset;
    logic       start_port;
    logic [6:0] src_addr;
    logic [6:0] dst_addr;
    logic [7:0] len;
    logic       done_port;
    logic       error_port;
    logic       busy;
    logic       Mout_oe_ram;
    logic       Mout_we_ram;
    logic [6:0] Mout_addr_ram;
    logic [7:0] Mout_Wdata_ram;
    logic [3:0] Mout_data_ram_size;
    logic [7:0] M_Rdata_ram;
    logic       M_DataRdy;

    bambu_copy_master #(.ADDR_W(7), .DATA_W(8), .WAIT_LIMIT(WL)) dut (
        .clock              (clock),
        .reset              (reset),
        .start_port         (start_port),
        .src_addr           (src_addr),
        .dst_addr           (dst_addr),
        .len                (len),
        .done_port          (done_port),
        .error_port         (error_port),
        .busy               (busy),
        .Mout_oe_ram        (Mout_oe_ram),
        .Mout_we_ram        (Mout_we_ram),
        .Mout_addr_ram      (Mout_addr_ram),
        .Mout_Wdata_ram     (Mout_Wdata_ram),
        .Mout_data_ram_size (Mout_data_ram_size),
        .M_Rdata_ram        (M_Rdata_ram),
        .M_DataRdy          (M_DataRdy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- responder ----------------
    logic [7:0] mem [128];
    logic [7:0] mm  [128];
    logic       load_mem = 1'b0;
    int         rd_d = 2;
    int         wr_d = 1;
    logic       hang_rd = 1'b0;
    logic       hang_wr = 1'b0;
    int         req_cnt = 0;
    logic       junk_rdy = 1'b0;
    logic [7:0] junk_data = 8'h00;

    always_comb begin
        if (Mout_oe_ram)      M_DataRdy = !hang_rd && (req_cnt == rd_d - 1);
        else if (Mout_we_ram) M_DataRdy = !hang_wr && (req_cnt == wr_d - 1);
        else                  M_DataRdy = junk_rdy;
        M_Rdata_ram = Mout_oe_ram ? mem[Mout_addr_ram] : junk_data;
    end

    always @(posedge clock) begin
        if ((Mout_oe_ram || Mout_we_ram) && !M_DataRdy) req_cnt <= req_cnt + 1;
        else req_cnt <= 0;
        if (load_mem) begin
            for (int i = 0; i < 128; i++) mem[i] <= mm[i];
        end else if (Mout_we_ram && M_DataRdy) begin
            mem[Mout_addr_ram] <= Mout_Wdata_ram;
        end
        junk_rdy  <= 1'($urandom_range(0, 1));
        junk_data <= 8'($urandom);
    end

    // ---------------- expectation script ----------------
    typedef struct packed {
        logic       oe;
        logic       we;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       done;
        logic       err;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    function automatic void push_e(input logic oe, input logic we,
                                   input logic [6:0] a, input logic [7:0] v,
                                   input logic dn, input logic er);
        exp_t e;
        e.oe = oe; e.we = we; e.addr = a; e.wdata = v;
        e.done = dn; e.err = er; e.busy = 1'b1;
        exp_q.push_back(e);
    endfunction

    // mode 0 = normal, 1 = reads never complete, 2 = writes never complete
    function automatic void build_script(input logic [6:0] s, input logic [6:0] d,
                                         input logic [7:0] n, input int rdd,
                                         input int wrd, input int mode);
        logic [6:0] a;
        logic [6:0] b;
        logic [7:0] v;
        bit         stop;
        stop = 0;
        if (n != 8'd0) begin
            if (mode == 1) begin
                for (int k = 0; k < WL; k++) push_e(1, 0, s, 8'h00, 0, 0);
            end else begin
                for (int i = 0; i < int'(n); i++) begin
                    if (!stop) begin
                        a = s + 7'(i);
                        b = d + 7'(i);
                        v = mm[a];
                        for (int k = 0; k < rdd; k++) push_e(1, 0, a, 8'h00, 0, 0);
                        if (mode == 2) begin
                            for (int k = 0; k < WL; k++) push_e(0, 1, b, v, 0, 0);
                            stop = 1;
                        end else begin
                            for (int k = 0; k < wrd; k++) push_e(0, 1, b, v, 0, 0);
                            mm[b] = v;
                        end
                    end
                end
            end
        end
        push_e(0, 0, 7'h00, 8'h00, 1, (n != 8'd0) && (mode != 0));
    endfunction

    // ---------------- per-cycle compare ----------------
    int         oe_cycles = 0;
    int         reads = 0;
    int         writes = 0;
    int         dones = 0;
    int         done_cyc = 0;
    logic       done_err = 1'b0;
    logic [6:0] rd_log[$];

    always @(negedge clock) begin
        exp_t e;
        bit   bad;
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        bad = 0;
        if (Mout_oe_ram !== e.oe || Mout_we_ram !== e.we) bad = 1;
        if (done_port !== e.done || error_port !== e.err || busy !== e.busy) bad = 1;
        if (Mout_data_ram_size !== ((e.oe | e.we) ? 4'd8 : 4'd0)) bad = 1;
        if ((e.oe | e.we) && Mout_addr_ram !== e.addr) bad = 1;
        if (e.we && Mout_Wdata_ram !== e.wdata) bad = 1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL cycle %0d outputs oe/we/addr/wdata/size/done/err/busy got %b/%b/%h/%h/%0d/%b/%b/%b required %b/%b/%h/%h/-/%b/%b/%b",
                     cyc, Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram,
                     Mout_data_ram_size, done_port, error_port, busy,
                     e.oe, e.we, e.addr, e.wdata, e.done, e.err, e.busy);
        end
        if (Mout_oe_ram === 1'b1) oe_cycles++;
        if (Mout_oe_ram === 1'b1 && M_DataRdy) begin
            reads++;
            rd_log.push_back(Mout_addr_ram);
        end
        if (Mout_we_ram === 1'b1 && M_DataRdy) writes++;
        if (done_port === 1'b1) begin
            dones++;
            done_cyc = cyc;
            done_err = error_port;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // ---------------- driver ----------------
    int t_acc = 0;

    task automatic sync_mem();
        @(posedge clock); #1;
        load_mem = 1'b1;
        @(posedge clock); #1;
        load_mem = 1'b0;
    endtask

    task automatic clear_stats();
        oe_cycles = 0; reads = 0; writes = 0; dones = 0;
        rd_log.delete();
    endtask

    task automatic start_copy(input logic [6:0] s, input logic [6:0] d, input logic [7:0] n,
                              input int rdd, input int wrd, input int mode);
        @(posedge clock); #1;
        rd_d = rdd; wr_d = wrd;
        hang_rd = (mode == 1); hang_wr = (mode == 2);
        start_port = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(posedge clock); #1;
        t_acc = cyc - 1;
        build_script(s, d, n, rdd, wrd, mode);
        start_port = 1'b0;
    endtask

    task automatic run_copy(input logic [6:0] s, input logic [6:0] d, input logic [7:0] n,
                            input int rdd, input int wrd, input int mode, input int pulse_at);
        int k;
        start_copy(s, d, n, rdd, wrd, mode);
        k = 1;
        start_port = (k == pulse_at);
        src_addr = 7'($urandom); dst_addr = 7'($urandom); len = 8'($urandom_range(1, 9));
        while (exp_q.size() != 0) begin
            if (k > 3000) begin
                vectors++; miscompares++;
                $display("FAIL copy_timeout: got no completion after %0d cycles required completion", k);
                exp_q.delete();
            end else begin
                @(posedge clock); #1;
                k++;
                start_port = (k == pulse_at) && (exp_q.size() != 0);
            end
        end
        start_port = 1'b0;
    endtask

    function automatic int mem_diffs();
        int c;
        c = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== mm[i]) c++;
        return c;
    endfunction

    initial begin
        int         n0;
        logic [6:0] s;
        logic [6:0] d;
        logic [7:0] n;
        int         rdd;
        int         wrd;
        int         mode;
        int         r;

        reset = 1'b0; start_port = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        for (int i = 0; i < 128; i++) mm[i] = 8'($urandom);
        mm[7'h10] = 8'h11; mm[7'h11] = 8'h22; mm[7'h12] = 8'h33; mm[7'h13] = 8'h44;
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", busy, 0);
        check("reset_oe_we", {Mout_oe_ram, Mout_we_ram}, 0);
        check("reset_done_err", {done_port, error_port}, 0);
        check("reset_size", Mout_data_ram_size, 0);
        reset = 1'b1;
        sync_mem();

        // four-byte copy with 2/1 responder
        clear_stats();
        run_copy(7'h10, 7'h40, 8'd4, 2, 1, 0, -1);
        check("len4_latency", done_cyc - t_acc, 13);
        check("len4_error", done_err, 0);
        check("len4_byte0", mem[7'h40], 8'h11);
        check("len4_byte1", mem[7'h41], 8'h22);
        check("len4_byte2", mem[7'h42], 8'h33);
        check("len4_byte3", mem[7'h43], 8'h44);

        // zero-length copy
        clear_stats();
        run_copy(7'h05, 7'h60, 8'd0, 2, 1, 0, -1);
        check("len0_latency", done_cyc - t_acc, 1);
        check("len0_accesses", oe_cycles + writes, 0);
        check("len0_error", done_err, 0);

        // address wrap
        clear_stats();
        run_copy(7'h7E, 7'h20, 8'd3, 2, 1, 0, -1);
        check("wrap_reads", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            check("wrap_addr0", rd_log[0], 7'h7E);
            check("wrap_addr1", rd_log[1], 7'h7F);
            check("wrap_addr2", rd_log[2], 7'h00);
        end

        // read never completes
        clear_stats();
        run_copy(7'h30, 7'h50, 8'd4, 2, 1, 1, -1);
        check("hang_oe_cycles", oe_cycles, WL);
        check("hang_latency", done_cyc - t_acc, WL + 1);
        check("hang_error", done_err, 1);
        check("hang_mem", mem_diffs(), 0);

        // start pulsed during byte 2 of a five-byte copy
        clear_stats();
        run_copy(7'h08, 7'h68, 8'd5, 2, 1, 0, 7);
        check("ign_reads", reads, 5);
        check("ign_writes", writes, 5);
        check("ign_dones", dones, 1);
        check("ign_mem", mem_diffs(), 0);

        // reset during the write of byte 1
        clear_stats();
        start_copy(7'h30, 7'h50, 8'd3, 2, 1, 0);
        repeat (5) @(posedge clock);
        #2;
        check("pre_reset_we", Mout_we_ram, 1);
        check("pre_reset_addr", Mout_addr_ram, 7'h51);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_oe_we", {Mout_oe_ram, Mout_we_ram}, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_addr", Mout_addr_ram, 0);
        check("async_reset_size", Mout_data_ram_size, 0);
        n0 = dones;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("abort_no_done", dones, n0);
        sync_mem();
        run_copy(7'h30, 7'h50, 8'd2, 2, 1, 0, -1);
        check("post_reset_latency", done_cyc - t_acc, 7);
        check("post_reset_error", done_err, 0);
        check("post_reset_mem", mem_diffs(), 0);

        // randomized copies
        for (int t = 0; t < 40; t++) begin
            s = 7'($urandom);
            d = 7'($urandom);
            n = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            rdd = $urandom_range(1, 4);
            wrd = $urandom_range(1, 4);
            r = $urandom_range(0, 9);
            mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            run_copy(s, d, n, rdd, wrd, mode, $urandom_range(0, 30));
            if (n == 8'd0) begin
                check("rnd_latency", done_cyc - t_acc, 1);
                check("rnd_error", done_err, 0);
            end else if (mode == 1) begin
                check("rnd_latency", done_cyc - t_acc, 1 + WL);
                check("rnd_error", done_err, 1);
            end else if (mode == 2) begin
                check("rnd_latency", done_cyc - t_acc, 1 + rdd + WL);
                check("rnd_error", done_err, 1);
            end else begin
                check("rnd_latency", done_cyc - t_acc, 1 + int'(n) * (rdd + wrd));
                check("rnd_error", done_err, 0);
            end
            check("rnd_mem", mem_diffs(), 0);
        end

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
